// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and GF(2^8) helpers.
// The round-key buffer in aes_key_sched_seq is enabled with AES_KEYSCHED_BUF_EN.
package aes_pkg;

  localparam logic [3:0] AES_NR = 4'd10;

  typedef logic [127:0] rkey_t;
  typedef logic [3:0]   round_idx_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    r = x;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(r, r);
      r = gf_mul(r, x);
    end
    b = gf_mul(r, r);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input round_idx_t idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/KeyExpansionSeq.sv
// Combinational single-round AES-128 key expansion; byte i of a word/key sits at bits [8i+7:8i].
module KeyExpansionSeq
  import aes_pkg::*;
(
  input  rkey_t      key,
  input  round_idx_t counter,
  output rkey_t      nextKey
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = key[31:0];
  assign w_w1 = key[63:32];
  assign w_w2 = key[95:64];
  assign w_w3 = key[127:96];

  // RotWord moves byte 0 to the top byte position in this LSB-first layout.
  assign w_rot  = {w_w3[7:0], w_w3[31:8]};
  assign w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]),
                   sbox(w_rot[7:0]) ^ rcon(counter)};

  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign nextKey = {w_n3, w_n2, w_n1, w_n0};

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128 round-key streamer: one key in, round keys 0..10 out over valid/ready.
// Optional round-key buffer enabled by defining AES_KEYSCHED_BUF_EN.
module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             abort,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_round,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             buf_full
);

  localparam round_idx_t LAST_ROUND = round_idx_t'(NR);

  state_t           r_state;
  state_t           w_next_state;
  logic [KEY_W-1:0] r_cur_key;
  round_idx_t       r_round;
  logic             r_key_ready;
  logic             r_done;
  logic [KEY_W-1:0] w_next_key;
  logic             w_key_acc;
  logic             w_rk_hs;
  logic             w_last;

  KeyExpansionSeq u_expand (
    .key     (r_cur_key),
    .counter (r_round),
    .nextKey (w_next_key)
  );

  assign w_key_acc = (r_state == ST_IDLE) && key_valid && r_key_ready;
  assign w_rk_hs   = (r_state == ST_EMIT) && rk_ready;
  assign w_last    = (r_round == LAST_ROUND);

  // Next-state decode; abort wins over a concurrent handshake for the state change.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_key_acc) begin
          w_next_state = ST_EMIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (abort || (w_rk_hs && w_last)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_EMIT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, current key and round counter; key_ready is registered so it reads 0 right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur_key   <= {KEY_W{1'b0}};
      r_round     <= 4'd0;
      r_key_ready <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_key_ready <= (w_next_state == ST_IDLE);
      r_done      <= w_rk_hs && w_last && !abort;
      if (w_key_acc) begin
        r_cur_key <= key_in;
        r_round   <= 4'd0;
      end else if (w_rk_hs && !abort && !w_last) begin
        r_cur_key <= w_next_key;
        r_round   <= r_round + 4'd1;
      end else begin
        r_cur_key <= r_cur_key;
        r_round   <= r_round;
      end
    end
  end

  assign key_ready = r_key_ready;
  assign rk_valid  = (r_state == ST_EMIT);
  assign busy      = (r_state == ST_EMIT);
  assign rk_out    = r_cur_key;
  assign rk_round  = r_round;
  assign done      = r_done;

`ifdef AES_KEYSCHED_BUF_EN
  localparam int BUF_DEPTH = NR + 1;

  logic [KEY_W-1:0] r_buf [BUF_DEPTH];
  logic             r_buf_full;
  logic [KEY_W-1:0] w_rd_key;

  // Capture every transferred round key, including one handed over alongside an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= {KEY_W{1'b0}};
      end
      r_buf_full <= 1'b0;
    end else begin
      if (w_rk_hs) begin
        r_buf[r_round] <= r_cur_key;
      end else begin
        r_buf[r_round] <= r_buf[r_round];
      end
      if (w_key_acc || ((r_state == ST_EMIT) && abort)) begin
        r_buf_full <= 1'b0;
      end else if (w_rk_hs && w_last) begin
        r_buf_full <= 1'b1;
      end else begin
        r_buf_full <= r_buf_full;
      end
    end
  end

  // Read port; indices beyond the last round read as zero.
  always_comb begin
    w_rd_key = {KEY_W{1'b0}};
    if (rd_idx <= LAST_ROUND) begin
      w_rd_key = r_buf[rd_idx];
    end else begin
      w_rd_key = {KEY_W{1'b0}};
    end
  end

  assign rd_key   = w_rd_key;
  assign buf_full = r_buf_full;
`else
  logic w_unused_rd_idx;

  assign w_unused_rd_idx = ^rd_idx;
  assign rd_key          = {KEY_W{1'b0}};
  assign buf_full        = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Directed self-checking bench for aes_key_sched_seq against the FIPS-197 A.1 key schedule.
module tb_aes_key_sched_seq;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         abort;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         buf_full;

  int n_pass;
  int n_total;

  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] KEY_A = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
  localparam logic [127:0] KEY_Z = 128'h0;
  localparam logic [127:0] KEY_Z_R1 = 128'h63636362_63636362_63636362_63636362;

  aes_key_sched_seq dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .abort     (abort),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy),
    .done      (done),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key),
    .buf_full  (buf_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIPS-197 words are written big-endian; the DUT carries byte 0 in the LSBs.
  function automatic logic [127:0] fips2le(input logic [127:0] f);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = f[8*(15-i) +: 8];
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, {127'h0, key_ready}, 128'd0);
    check({tag, "_rk_valid"},  {127'h0, rk_valid},  128'd0);
    check({tag, "_rk_out"},    rk_out,              128'd0);
    check({tag, "_rk_round"},  {124'h0, rk_round},  128'd0);
    check({tag, "_busy"},      {127'h0, busy},      128'd0);
    check({tag, "_done"},      {127'h0, done},      128'd0);
    check({tag, "_buf_full"},  {127'h0, buf_full},  128'd0);
    check({tag, "_rd_key"},    rd_key,              128'd0);
  endtask

  task automatic accept_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  logic [15:0] stall_pat;
  int          exp_r;
  int          cyc;
  logic        hs;

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    key_in    = 128'h0;
    key_valid = 1'b0;
    abort     = 1'b0;
    rk_ready  = 1'b0;
    rd_idx    = 4'd0;
    stall_pat = 16'b1011_0010_0110_0001;

    exp_rk[0]  = fips2le(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    exp_rk[1]  = fips2le(128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    exp_rk[2]  = fips2le(128'hf2c295f2_7a96b943_5935807a_7359f67f);
    exp_rk[3]  = fips2le(128'h3d80477d_4716fe3e_1e237e44_6d7a883b);
    exp_rk[4]  = fips2le(128'hef44a541_a8525b7f_b671253b_db0bad00);
    exp_rk[5]  = fips2le(128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc);
    exp_rk[6]  = fips2le(128'h6d88a37a_110b3efd_dbf98641_ca0093fd);
    exp_rk[7]  = fips2le(128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f);
    exp_rk[8]  = fips2le(128'head27321_b58dbad2_312bf560_7f8d292f);
    exp_rk[9]  = fips2le(128'hac7766f3_19fadc21_28d12941_575c006e);
    exp_rk[10] = fips2le(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();
    check("rst_release_key_ready", {127'h0, key_ready}, 128'd1);

    // Full FIPS-197 schedule, rk_ready held high
    rk_ready = 1'b1;
    accept_key(KEY_A);
    check("fips_key_ready_low", {127'h0, key_ready}, 128'd0);
    check("fips_busy", {127'h0, busy}, 128'd1);
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("fips_valid_r%0d", r), {127'h0, rk_valid}, 128'd1);
      check($sformatf("fips_round_r%0d", r), {124'h0, rk_round}, 128'(r));
      check($sformatf("fips_key_r%0d", r), rk_out, exp_rk[r]);
      tick();
    end
    check("fips_r1_literal", exp_rk[1], 128'h05766c2a_3939a323_b12c5488_17fefaa0);
    check("fips_done", {127'h0, done}, 128'd1);
    check("fips_done_rk_valid", {127'h0, rk_valid}, 128'd0);
    check("fips_done_key_ready", {127'h0, key_ready}, 128'd1);
    check("fips_done_busy", {127'h0, busy}, 128'd0);
`ifdef AES_KEYSCHED_BUF_EN
    check("buf_full_set", {127'h0, buf_full}, 128'd1);
    rd_idx = 4'd1;
    #1;
    check("buf_rd1", rd_key, 128'h05766c2a_3939a323_b12c5488_17fefaa0);
    rd_idx = 4'd10;
    #1;
    check("buf_rd10", rd_key, 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0);
    rd_idx = 4'd15;
    #1;
    check("buf_rd15", rd_key, 128'd0);
    rd_idx = 4'd0;
    #1;
    check("buf_rd0", rd_key, KEY_A);
`else
    rd_idx = 4'd1;
    #1;
    check("nobuf_rd_key", rd_key, 128'd0);
    check("nobuf_buf_full", {127'h0, buf_full}, 128'd0);
    rd_idx = 4'd0;
`endif
    tick();
    check("fips_done_pulse_end", {127'h0, done}, 128'd0);

    // Backpressure: same keys in order, held while stalled
    rk_ready = 1'b0;
    accept_key(KEY_A);
`ifdef AES_KEYSCHED_BUF_EN
    check("buf_full_clear_on_accept", {127'h0, buf_full}, 128'd0);
`endif
    exp_r = 0;
    cyc   = 0;
    while (exp_r <= 10 && cyc < 200) begin
      rk_ready = stall_pat[cyc % 16];
      hs       = rk_ready;
      check($sformatf("bp_valid_c%0d", cyc), {127'h0, rk_valid}, 128'd1);
      check($sformatf("bp_round_c%0d", cyc), {124'h0, rk_round}, 128'(exp_r));
      check($sformatf("bp_key_c%0d", cyc), rk_out, exp_rk[exp_r]);
      tick();
      if (hs) begin
        exp_r++;
      end
      cyc++;
    end
    check("bp_all_rounds_seen", 128'(exp_r), 128'd11);
    check("bp_done", {127'h0, done}, 128'd1);
    rk_ready = 1'b0;
    tick();

    // Abort at round 4 with a concurrent handshake
    rk_ready = 1'b1;
    accept_key(KEY_A);
    for (int r = 0; r < 4; r++) begin
      tick();
    end
    check("abort_at_round4", {124'h0, rk_round}, 128'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rk_valid", {127'h0, rk_valid}, 128'd0);
    check("abort_busy", {127'h0, busy}, 128'd0);
    check("abort_no_done", {127'h0, done}, 128'd0);
    check("abort_key_ready", {127'h0, key_ready}, 128'd1);
`ifdef AES_KEYSCHED_BUF_EN
    rd_idx = 4'd4;
    #1;
    check("abort_buf_r4", rd_key, exp_rk[4]);
    check("abort_buf_not_full", {127'h0, buf_full}, 128'd0);
    rd_idx = 4'd0;
`endif
    tick();
    check("abort_no_done_later", {127'h0, done}, 128'd0);
    check("abort_still_idle", {127'h0, rk_valid}, 128'd0);

    // Abort in IDLE is ignored; reset at round 7
    abort = 1'b1;
    accept_key(KEY_A);
    abort = 1'b0;
    check("idle_abort_ignored", {127'h0, rk_valid}, 128'd1);
    for (int r = 0; r < 7; r++) begin
      tick();
    end
    check("rst_mid_round7", {124'h0, rk_round}, 128'd7);
    check("rst_mid_key7", rk_out, exp_rk[7]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    tick();
    check("rst_mid_key_ready", {127'h0, key_ready}, 128'd1);
    accept_key(KEY_A);
    check("restart_round0", {124'h0, rk_round}, 128'd0);
    check("restart_key0", rk_out, exp_rk[0]);
    tick();
    check("restart_key1", rk_out, exp_rk[1]);
    for (int r = 1; r <= 10; r++) begin
      tick();
    end
    check("restart_done", {127'h0, done}, 128'd1);

    // key_valid held through a schedule with a different key
    tick();
    key_in    = KEY_A;
    key_valid = 1'b1;
    tick();
    key_in = KEY_Z;
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("hold_key_r%0d", r), rk_out, exp_rk[r]);
      tick();
    end
    check("hold_done", {127'h0, done}, 128'd1);
    check("hold_done_key_ready", {127'h0, key_ready}, 128'd1);
    tick();
    key_valid = 1'b0;
    check("hold_second_valid", {127'h0, rk_valid}, 128'd1);
    check("hold_second_round0", {124'h0, rk_round}, 128'd0);
    check("hold_second_key0", rk_out, KEY_Z);
    tick();
    check("hold_second_key1", rk_out, KEY_Z_R1);
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    rk_ready = 1'b0;
    check("final_idle", {127'h0, rk_valid}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
